shift_reg_piso: RTL and testbench
=================================

Name: shift_reg_piso

Overview:
- Parallel-in, serial-out shift register that serialises one glyph row byte into a 1-bit pixel stream.
- Sits between the GPU's glyph-ROM fetch logic and the RGB output stage.
- The GPU loads a byte near the end of each 8-pixel cell and shifts once per visible pixel clock.
- data_out selects foreground (1) or background (0) colour.

Parameters:
- WIDTH, 8, number of bits held and serialised per load.
- MSB_FIRST, 1, 1 = serialise bit WIDTH-1 first (shift left); 0 = serialise bit 0 first (shift right).
- FILL_BIT, 1'b0, value shifted into the vacated end on each shift.

Ports:
- clk  input  1  pixel clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel byte to load.
- data_in_enable  input  1  load strobe; samples data_in at the clock edge.
- shift_enable  input  1  advance the serial stream by one bit at the clock edge.
- data_out  output  1  current serial bit, combinational from the register.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Internal state: register sr[WIDTH-1:0].
- Reset: rst=1 at a rising edge sets sr to all zeros, so data_out=0 from the next cycle. Reset overrides load and shift.
- Output mapping: data_out = sr[WIDTH-1] when MSB_FIRST=1, sr[0] when MSB_FIRST=0. There is no extra register stage; the change is visible in the same cycle sr updates.
- Priority at each rising edge, with rst=0:
  - data_in_enable=1: sr <= data_in. This applies even if shift_enable=1; load wins and no shift happens that cycle.
  - Otherwise, if shift_enable=1 and MSB_FIRST=1: sr <= {sr[WIDTH-2:0], FILL_BIT}.
  - Otherwise, if shift_enable=1 and MSB_FIRST=0: sr <= {FILL_BIT, sr[WIDTH-1:1]}.
  - Otherwise sr holds.
- Load latency: data_in loaded at edge N drives data_out with its first bit after edge N.
  - Each subsequent shift edge exposes the next bit.
  - After WIDTH shifts with no reload, sr contains only FILL_BIT.
- Shifts after exhaustion keep shifting FILL_BIT; there is no error or wrap.
- Holding shift_enable=0 freezes data_out indefinitely, e.g. during blanking.
- Back-to-back loads: every load fully replaces sr. A reload mid-stream discards the remaining bits.
- X-safety: with no load since reset, data_out is a defined 0.

Optional Feature:
- Macro: SHIFT_REG_STATUS_EN.
- When defined, add two outputs:
  - bits_left (width $clog2(WIDTH+1)):
    - reset 0;
    - set to WIDTH on load;
    - decrements by 1 on each shift while nonzero;
    - saturates at 0.
  - empty (1 bit): bits_left==0, combinational.
- Load-over-shift priority also applies to bits_left: a simultaneous load and shift gives WIDTH.
- When undefined, neither port nor counter exists. data_out behaviour is identical either way.

Decomposition:
- Package shift_reg_pkg holds:
  - SHIFT_REG_DEFAULT_WIDTH = 8;
  - the direction constants SHIFT_DIR_MSB = 1 and SHIFT_DIR_LSB = 0.
- The GPU imports the same width constant for glyph rows.
- Optional sub-module shift_reg_bitcnt implements the saturating bits_left counter. It is instantiated only under SHIFT_REG_STATUS_EN.
- The core register needs no further split.

Test Plan:
- Reset: run with rst=1 for 2 cycles and both strobes active. Then sr=0, data_out=0, and bits_left=0 (with feature).
- Load 8'b1011_0010 then shift 8 cycles (MSB_FIRST=1). data_out = 1,0,1,1,0,0,1,0 across the load cycle and the next 7 shifts, then 0 with bits_left=0 and empty=1.
- Simultaneous load and shift with data_in=8'hFF after sr=8'h00. sr=8'hFF, data_out=1, no shift that cycle, bits_left=8.
- Hold: load 8'h80, shift once, then shift_enable=0 for 10 cycles. data_out stays 0 and sr stays 8'h00. Repeat with 8'hC0: data_out stays 1 through the hold.
- MSB_FIRST=0, FILL_BIT=1: load 8'b0000_0001 and shift 9 times. data_out = 1, then 0 for 7 shifts, then 1 from the fill bits.
- Mid-stream reload and synchronous reset:
  - Load 8'hF0, shift 2, load 8'h0F: data_out=0 the next cycle.
  - Assert rst together with data_in_enable: sr=0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared constants and load/shift arbitration for the glyph-row PISO shifter.
// Imported by the GPU for the glyph row width and by every shift_reg_* block.
package shift_reg_pkg;

    localparam int SHIFT_REG_DEFAULT_WIDTH = 8;

    localparam bit SHIFT_DIR_MSB = 1'b1;
    localparam bit SHIFT_DIR_LSB = 1'b0;

    typedef enum logic [1:0] {
        SR_OP_HOLD  = 2'd0,
        SR_OP_SHIFT = 2'd1,
        SR_OP_LOAD  = 2'd2
    } sr_op_e;

    // A load always beats a shift in the same cycle; the shift is dropped, not deferred.
    function automatic sr_op_e sr_op_select(input logic load, input logic shift);
        sr_op_e op;
        if (load) begin
            op = SR_OP_LOAD;
        end else if (shift) begin
            op = SR_OP_SHIFT;
        end else begin
            op = SR_OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/shift_reg_bitcnt.sv
// Saturating "bits remaining" counter that tracks a shift_reg_piso stream.
// Only instantiated when SHIFT_REG_STATUS_EN is defined.
module shift_reg_bitcnt
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = SHIFT_REG_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  sr_op_e           op,
    output logic [CNT_W-1:0] bits_left,
    output logic             empty
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    // Next count: reload to WIDTH, count down on shift, stick at zero once drained.
    always_comb begin
        count_next_s = count_r;
        case (op)
            SR_OP_LOAD: begin
                count_next_s = CNT_W'(WIDTH);
            end
            SR_OP_SHIFT: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    count_next_s = count_r - CNT_W'(1);
                end else begin
                    count_next_s = count_r;
                end
            end
            SR_OP_HOLD: begin
                count_next_s = count_r;
            end
            default: begin
                count_next_s = count_r;
            end
        endcase
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign bits_left = count_r;
    assign empty     = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shifter turning one glyph row into a fg/bg pixel stream.
// Define SHIFT_REG_STATUS_EN to add the bits_left / empty status outputs.
module shift_reg_piso
    import shift_reg_pkg::*;
#(
    parameter int   WIDTH     = SHIFT_REG_DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = SHIFT_DIR_MSB,
    parameter logic FILL_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_enable,
    input  logic             shift_enable,
`ifdef SHIFT_REG_STATUS_EN
    output logic [$clog2(WIDTH+1)-1:0] bits_left,
    output logic                       empty,
`endif
    output logic             data_out
);

    sr_op_e           op_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_next_s;
    logic [WIDTH-1:0] shifted_s;

    assign op_s = sr_op_select(data_in_enable, shift_enable);

    // Direction is fixed at elaboration, so only one shift network and tap exist.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted_s = {sr_r[WIDTH-2:0], FILL_BIT};
            assign data_out  = sr_r[WIDTH-1];
        end else begin : g_lsb_first
            assign shifted_s = {FILL_BIT, sr_r[WIDTH-1:1]};
            assign data_out  = sr_r[0];
        end
    endgenerate

    // Next register value chosen by the load/shift/hold arbitration.
    always_comb begin
        sr_next_s = sr_r;
        case (op_s)
            SR_OP_LOAD: begin
                sr_next_s = data_in;
            end
            SR_OP_SHIFT: begin
                sr_next_s = shifted_s;
            end
            SR_OP_HOLD: begin
                sr_next_s = sr_r;
            end
            default: begin
                sr_next_s = sr_r;
            end
        endcase
    end

    // Shift register; reset forces zero so data_out is defined before the first load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r <= {WIDTH{1'b0}};
        end else begin
            sr_r <= sr_next_s;
        end
    end

`ifdef SHIFT_REG_STATUS_EN
    shift_reg_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk       (clk),
        .rst       (rst),
        .op        (op_s),
        .bits_left (bits_left),
        .empty     (empty)
    );
`endif

endmodule

// File: tb/tb_shift_reg_piso.sv
// Self-checking bench for shift_reg_piso: an MSB-first/fill-0 and an LSB-first/fill-1
// instance share stimulus and are compared against a queue-style stream model.
module tb_shift_reg_piso;

    localparam int W   = 8;
    localparam int CW  = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_in_enable = 1'b0;
    logic         shift_enable = 1'b0;
    logic         out_msb;
    logic         out_lsb;
`ifdef SHIFT_REG_STATUS_EN
    logic [CW-1:0] bits_left_msb;
    logic [CW-1:0] bits_left_lsb;
    logic          empty_msb;
    logic          empty_lsb;
`endif

    int checks_n   = 0;
    int failures_n = 0;

    // Reference: m_*[0] is the bit currently on data_out, later indices come out later.
    logic m_msb [W];
    logic m_lsb [W];
    int   m_cnt;

    always #5 clk = ~clk;

    shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut_msb (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_enable (data_in_enable),
        .shift_enable   (shift_enable),
`ifdef SHIFT_REG_STATUS_EN
        .bits_left      (bits_left_msb),
        .empty          (empty_msb),
`endif
        .data_out       (out_msb)
    );

    shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b0), .FILL_BIT(1'b1)) dut_lsb (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_enable (data_in_enable),
        .shift_enable   (shift_enable),
`ifdef SHIFT_REG_STATUS_EN
        .bits_left      (bits_left_lsb),
        .empty          (empty_lsb),
`endif
        .data_out       (out_lsb)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            failures_n++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic ld, input logic sh, input logic [W-1:0] d);
        if (r) begin
            for (int i = 0; i < W; i++) begin
                m_msb[i] = 1'b0;
                m_lsb[i] = 1'b0;
            end
            m_cnt = 0;
        end else if (ld) begin
            for (int i = 0; i < W; i++) begin
                m_msb[i] = d[W-1-i];
                m_lsb[i] = d[i];
            end
            m_cnt = W;
        end else if (sh) begin
            for (int i = 0; i < W-1; i++) begin
                m_msb[i] = m_msb[i+1];
                m_lsb[i] = m_lsb[i+1];
            end
            m_msb[W-1] = 1'b0;
            m_lsb[W-1] = 1'b1;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end
    endtask

    function automatic logic [W-1:0] exp_sr_msb();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[W-1-i] = m_msb[i];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_sr_lsb();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_lsb[i];
        return v;
    endfunction

    // Drive one cycle from the falling edge, update the model at the rising edge, check 1 ns later.
    task automatic step(input logic r, input logic ld, input logic sh, input logic [W-1:0] d);
        rst = r; data_in_enable = ld; shift_enable = sh; data_in = d;
        @(posedge clk);
        model_update(r, ld, sh, d);
        #1;
        check_value("out_msb", 32'(out_msb), 32'(m_msb[0]));
        check_value("out_lsb", 32'(out_lsb), 32'(m_lsb[0]));
        check_value("sr_msb", 32'(dut_msb.sr_r), 32'(exp_sr_msb()));
        check_value("sr_lsb", 32'(dut_lsb.sr_r), 32'(exp_sr_lsb()));
`ifdef SHIFT_REG_STATUS_EN
        check_value("bits_left_msb", 32'(bits_left_msb), 32'(m_cnt));
        check_value("bits_left_lsb", 32'(bits_left_lsb), 32'(m_cnt));
        check_value("empty_msb", 32'(empty_msb), 32'(m_cnt == 0));
        check_value("empty_lsb", 32'(empty_lsb), 32'(m_cnt == 0));
`endif
        @(negedge clk);
    endtask

    logic [W-1:0] pat;

    initial begin
        for (int i = 0; i < W; i++) begin
            m_msb[i] = 1'b0;
            m_lsb[i] = 1'b0;
        end
        m_cnt = 0;
        @(negedge clk);

        // Reset with both strobes active must still clear.
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        check_value("reset_out", 32'(out_msb), 32'd0);
        check_value("reset_sr", 32'(dut_msb.sr_r), 32'd0);

        // Load B2 then shift: fixed expected pixel sequence.
        pat = 8'b1011_0010;
        step(1'b0, 1'b1, 1'b0, pat);
        check_value("b2_bit0", 32'(out_msb), 32'd1);
        for (int i = 1; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check_value("b2_seq", 32'(out_msb), 32'(pat[W-1-i]));
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_value("b2_drained", 32'(out_msb), 32'd0);

        // Simultaneous load and shift: load wins.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        check_value("ld_sh_sr", 32'(dut_msb.sr_r), 32'hFF);

        // Hold after one shift.
        step(1'b0, 1'b1, 1'b0, 8'h80);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check_value("hold_80", 32'(out_msb), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'hC0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check_value("hold_c0", 32'(out_msb), 32'd1);

        // LSB-first with fill 1: 1, seven 0s, then fill 1s.
        step(1'b0, 1'b1, 1'b0, 8'b0000_0001);
        check_value("lsb_first", 32'(out_lsb), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check_value("lsb_seq", 32'(out_lsb), (i >= 8) ? 32'd1 : 32'd0);
        end

        // Mid-stream reload, then reset together with load.
        step(1'b0, 1'b1, 1'b0, 8'hF0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h0F);
        check_value("reload_out", 32'(out_msb), 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        check_value("rst_over_load", 32'(dut_msb.sr_r), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end

endmodule
